wb_master_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter. It lets the core's data-side and instruction-side wishbone_bus_if instances share a single external Wishbone bus. Master 0 is the data port (MEM stage) and master 1 is the instruction port (IF stage). It sits between the core top level and the SoC interconnect, where the UART and GPIO slaves live.

---
 rtl/wb_master_arbiter_if.sv | 61 ++++++
 rtl/wb_master_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_master_arbiter_if.sv
// Bundle of every bus signal around wb_master_arbiter: two master ports, one slave port, grant and FSM state.
// The arbiter connects through the slave modport; the core/SoC environment connects through the master modport.
interface wb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    // Master 0: data port (MEM stage)
    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [DATA_W-1:0] m0_data_o;
    logic              m0_ack_o;

    // Master 1: instruction port (IF stage)
    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [DATA_W-1:0] m1_data_o;
    logic              m1_ack_o;

    // Shared slave side
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_data_o;
    logic [SEL_W-1:0]  s_sel_o;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ack_i;

    // Registered grant (bit0 = m0, bit1 = m1) and raw FSM state for debug
    logic [1:0]        grant_o;
    logic [1:0]        state_o;

    // Handshake: a master owns the bus from its grant until it drops cyc; each beat
    // completes on a cycle with stb=1 and ack=1; the ungranted master holds cyc and waits.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
        input  s_data_i, s_ack_i,
        output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        output grant_o, state_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i,
        output s_data_i, s_ack_i,
        input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        input  grant_o, state_o
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter: m0 = data port, m1 = instruction port; fixed m0 priority.
// Define WB_ARB_RR_EN to break simultaneous requests round-robin using a last-grant flag.
module wb_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_master_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] ZERO_A = '0;
    localparam logic [DATA_W-1:0] ZERO_D = '0;
    localparam logic [SEL_W-1:0]  ZERO_S = '0;

    state_e state_q, state_d;
    state_e req_state;
    logic   gnt0, gnt1;

`ifdef WB_ARB_RR_EN
    // 0 = m0 was granted last, 1 = m1 was granted last
    logic last_grant_q, last_grant_d;
`endif

    // Request evaluation, shared by IDLE and by the release edge of either grant
    always_comb begin
        req_state = IDLE;
`ifdef WB_ARB_RR_EN
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
            req_state = last_grant_q ? GNT_M0 : GNT_M1;
        end else if (bus.m0_cyc_i) begin
            req_state = GNT_M0;
        end else if (bus.m1_cyc_i) begin
            req_state = GNT_M1;
        end
`else
        if (bus.m0_cyc_i) begin
            req_state = GNT_M0;
        end else if (bus.m1_cyc_i) begin
            req_state = GNT_M1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_state;
            GNT_M0:  if (!bus.m0_cyc_i) state_d = req_state;
            GNT_M1:  if (!bus.m1_cyc_i) state_d = req_state;
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_d == GNT_M0 && state_q != GNT_M0) begin
            last_grant_d = 1'b0;
        end else if (state_d == GNT_M1 && state_q != GNT_M1) begin
            last_grant_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
`ifdef WB_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
`ifdef WB_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign gnt0 = (state_q == GNT_M0);
    assign gnt1 = (state_q == GNT_M1);

    assign bus.grant_o = {gnt1, gnt0};
    assign bus.state_o = state_q;

    // Slave side follows the granted master combinationally, so a dropped cyc is seen at once
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_addr_o = ZERO_A;
        bus.s_data_o = ZERO_D;
        bus.s_sel_o  = ZERO_S;
        if (gnt0) begin
            bus.s_cyc_o  = bus.m0_cyc_i;
            bus.s_stb_o  = bus.m0_stb_i;
            bus.s_we_o   = bus.m0_we_i;
            bus.s_addr_o = bus.m0_addr_i;
            bus.s_data_o = bus.m0_data_i;
            bus.s_sel_o  = bus.m0_sel_i;
        end else if (gnt1) begin
            bus.s_cyc_o  = bus.m1_cyc_i;
            bus.s_stb_o  = bus.m1_stb_i;
            bus.s_we_o   = bus.m1_we_i;
            bus.s_addr_o = bus.m1_addr_i;
            bus.s_data_o = bus.m1_data_i;
            bus.s_sel_o  = bus.m1_sel_i;
        end
    end

    // Acks outside an active strobe of the granted master are dropped here
    always_comb begin
        bus.m0_ack_o  = bus.s_ack_i & gnt0 & bus.m0_stb_i;
        bus.m1_ack_o  = bus.s_ack_i & gnt1 & bus.m1_stb_i;
        bus.m0_data_o = gnt0 ? bus.s_data_i : ZERO_D;
        bus.m1_data_o = gnt1 ? bus.s_data_i : ZERO_D;
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.grant_o));

    a_single_ack: assert property (@(posedge clk) disable iff (!rst)
        !(bus.m0_ack_o && bus.m1_ack_o));

    a_cyc_needs_grant: assert property (@(posedge clk) disable iff (!rst)
        bus.s_cyc_o |-> (bus.grant_o != 2'b00));

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: per-cycle vector table plus a repeated-contention sequence.
// Expectations for simultaneous requests follow WB_ARB_RR_EN when it is defined.
module tb_wb_master_arbiter;

    localparam logic [31:0] M0_ADDR = 32'h2000_0000;
    localparam logic [31:0] M0_DATA = 32'h1234_5678;
    localparam logic [3:0]  M0_SEL  = 4'hF;
    localparam logic [31:0] M1_ADDR = 32'h0000_0100;
    localparam logic [31:0] M1_DATA = 32'hAAAA_5555;
    localparam logic [3:0]  M1_SEL  = 4'h3;
    localparam logic [31:0] S_RDATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

    wb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // m0/m1 fields are {cyc, stb, we}; expected values are for the same cycle the inputs are applied
    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] m0;
        logic [2:0] m1;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc;
        logic       m0a;
        logic       m1a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic [2:0] a, logic [2:0] b, logic k,
                                logic [1:0] g, logic sc, logic a0, logic a1);
        vec_t v;
        v.name = n; v.rst = r; v.m0 = a; v.m1 = b; v.ack = k;
        v.gnt = g; v.scyc = sc; v.m0a = a0; v.m1a = a1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic [2:0] a, logic [2:0] b, logic k);
        rst          = r;
        bus.m0_cyc_i = a[2];
        bus.m0_stb_i = a[1];
        bus.m0_we_i  = a[0];
        bus.m1_cyc_i = b[2];
        bus.m1_stb_i = b[1];
        bus.m1_we_i  = b[0];
        bus.s_ack_i  = k;
    endtask

    task automatic check_vec(vec_t v);
        logic [31:0] e_addr, e_wdata, e_m0d, e_m1d;
        logic [3:0]  e_sel;
        logic        e_stb, e_we;
        e_addr = '0; e_wdata = '0; e_sel = '0; e_stb = 1'b0; e_we = 1'b0;
        e_m0d = '0; e_m1d = '0;
        if (v.gnt == 2'b01) begin
            e_addr = M0_ADDR; e_wdata = M0_DATA; e_sel = M0_SEL;
            e_stb = v.m0[1]; e_we = v.m0[0]; e_m0d = S_RDATA;
        end else if (v.gnt == 2'b10) begin
            e_addr = M1_ADDR; e_wdata = M1_DATA; e_sel = M1_SEL;
            e_stb = v.m1[1]; e_we = v.m1[0]; e_m1d = S_RDATA;
        end
        chk({v.name, " grant"},  32'(bus.grant_o),  32'(v.gnt));
        chk({v.name, " s_cyc"},  32'(bus.s_cyc_o),  32'(v.scyc));
        chk({v.name, " s_stb"},  32'(bus.s_stb_o),  32'(e_stb));
        chk({v.name, " s_we"},   32'(bus.s_we_o),   32'(e_we));
        chk({v.name, " s_addr"}, bus.s_addr_o,      e_addr);
        chk({v.name, " s_data"}, bus.s_data_o,      e_wdata);
        chk({v.name, " s_sel"},  32'(bus.s_sel_o),  32'(e_sel));
        chk({v.name, " m0_ack"}, 32'(bus.m0_ack_o), 32'(v.m0a));
        chk({v.name, " m1_ack"}, 32'(bus.m1_ack_o), 32'(v.m1a));
        chk({v.name, " m0_dat"}, bus.m0_data_o,     e_m0d);
        chk({v.name, " m1_dat"}, bus.m1_data_o,     e_m1d);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] got_g;
        bit         seen;

        bus.m0_addr_i = M0_ADDR; bus.m0_data_i = M0_DATA; bus.m0_sel_i = M0_SEL;
        bus.m1_addr_i = M1_ADDR; bus.m1_data_i = M1_DATA; bus.m1_sel_i = M1_SEL;
        bus.s_data_i  = S_RDATA;
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        tick();

        //              name      rst  m0      m1      ack   gnt    scyc  a0    a1
        vecs.push_back(mk("rst_a",  0, 3'b100, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rst_b",  0, 3'b100, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("rel",    1, 3'b100, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("g0_nstb",1, 3'b100, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("flush",  1, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("idl_ack",1, 3'b000, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("m1_req", 1, 3'b000, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("m1_w1",  1, 3'b000, 3'b110, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("m1_w2",  1, 3'b000, 3'b110, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("m1_w3",  1, 3'b000, 3'b110, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("m1_ack", 1, 3'b000, 3'b110, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("m1_rel", 1, 3'b000, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("both_rq",1, 3'b111, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("m0_wr",  1, 3'b111, 3'b110, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("m0_wack",1, 3'b111, 3'b110, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("m0_rel", 1, 3'b000, 3'b110, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("m1_hand",1, 3'b000, 3'b110, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("no_pre", 1, 3'b111, 3'b110, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("no_preA",1, 3'b111, 3'b110, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("m1_drop",1, 3'b111, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("m0_take",1, 3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("m0_end", 1, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("mr_req", 1, 3'b110, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("mr_rst", 0, 3'b110, 3'b000, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("mr_aft", 1, 3'b110, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("mr_gnt", 1, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("idle",   1, 3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].m0, vecs[i].m1, vecs[i].ack);
            #3;
            check_vec(vecs[i]);
            tick();
        end

        // Repeated contention from IDLE with a fresh last-grant flag after reset
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        tick();
        for (int r = 0; r < 4; r++) begin
`ifdef WB_ARB_RR_EN
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            drive(1'b1, 3'b110, 3'b110, 1'b0);
            seen  = 1'b0;
            got_g = 2'b00;
            for (int k = 0; k < 4 && !seen; k++) begin
                tick();
                if (bus.grant_o != 2'b00) begin
                    seen  = 1'b1;
                    got_g = bus.grant_o;
                end
            end
            if (!seen) begin
                chk($sformatf("rr%0d grant_timeout", r), 32'(got_g), 32'(exp_g));
            end else begin
                chk($sformatf("rr%0d grant", r), 32'(got_g), 32'(exp_g));
                bus.s_ack_i = 1'b1;
                #2;
                chk($sformatf("rr%0d m0_ack", r), 32'(bus.m0_ack_o), 32'(exp_g[0]));
                chk($sformatf("rr%0d m1_ack", r), 32'(bus.m1_ack_o), 32'(exp_g[1]));
                tick();
                drive(1'b1, 3'b000, 3'b000, 1'b0);
                tick();
                chk($sformatf("rr%0d released", r), 32'(bus.grant_o), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
